// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 keyboard receiver and game command decoder
//
// Receives PS/2 frames on the raw ps2_clk/ps2_data pins and turns the scancodes
// into level-held game commands for the downstream drawing/physics stage.
//
// Ports:
//   clk          system clock (only clock)
//   rst_n        asynchronous active-low reset
//   ps2_clk      raw PS/2 clock line (asynchronous)
//   ps2_data     raw PS/2 data line (asynchronous)
//   up[4:0]      5'h0A restart (R held), 5'h09 flap (Space/Up held), 5'h00 none
//   gamepause    pause level, toggles on each fresh press of P
//   scan_code    last correctly received byte
//   frame_valid  one-cycle pulse per accepted byte
//   frame_err    one-cycle pulse on parity, stop or timeout error
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] up,
  output logic       gamepause,
  output logic [7:0] scan_code,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1, clk_s2, clk_h;
  logic          dat_s1, dat_s2;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;

  logic brk, ext, r_held, space_held, arrow_held, p_held;
  logic n_brk, n_ext, n_r, n_space, n_arrow, n_p, n_pause;
  logic [4:0] n_up;

  logic fall, accept, bad_frame, timeout;

  assign fall      = clk_h & ~clk_s2;
  // Odd parity over data + parity bit, and stop bit must be 1.
  assign accept    = fall && (state == S_STOP) && dat_s2 && (^{shreg, par_bit});
  assign bad_frame = fall && (state == S_STOP) && !accept;
  assign timeout   = !fall && (state != S_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));

  // Next-state of the key flags; held flags and the encoded outputs are all
  // registered from these values so they change in the same cycle.
  always_comb begin
    n_brk   = brk;
    n_ext   = ext;
    n_r     = r_held;
    n_space = space_held;
    n_arrow = arrow_held;
    n_p     = p_held;
    n_pause = gamepause;
    if (bad_frame || timeout) begin
      n_brk = 1'b0;
      n_ext = 1'b0;
    end else if (accept) begin
      if (shreg == 8'hF0) begin
        n_brk = 1'b1;
      end else if (shreg == 8'hE0) begin
        n_ext = 1'b1;
      end else begin
        n_brk = 1'b0;
        n_ext = 1'b0;
        if (!ext) begin
          case (shreg)
            8'h29: n_space = !brk;
            8'h2D: n_r     = !brk;
            8'h4D: begin
              n_p = !brk;
              // Typematic repeats arrive with p_held already set.
              if (!brk && !p_held) n_pause = !gamepause;
            end
            default: ;
          endcase
        end else if (shreg == 8'h75) begin
          n_arrow = !brk;
        end
      end
    end
    if (n_r)                    n_up = 5'h0A;
    else if (n_space | n_arrow) n_up = 5'h09;
    else                        n_up = 5'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      clk_h       <= 1'b1;
      dat_s1      <= 1'b1;
      dat_s2      <= 1'b1;
      state       <= S_IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      par_bit     <= 1'b0;
      tcnt        <= '0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      r_held      <= 1'b0;
      space_held  <= 1'b0;
      arrow_held  <= 1'b0;
      p_held      <= 1'b0;
      gamepause   <= 1'b0;
      up          <= 5'h00;
      scan_code   <= 8'h00;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_h  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;

      if (fall) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (timeout) begin
          state <= S_IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end

      brk         <= n_brk;
      ext         <= n_ext;
      r_held      <= n_r;
      space_held  <= n_space;
      arrow_held  <= n_arrow;
      p_held      <= n_p;
      gamepause   <= n_pause;
      up          <= n_up;
      frame_valid <= accept;
      frame_err   <= bad_frame | timeout;
      if (accept) scan_code <= shreg;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;
  localparam int TO = 500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] up;
  logic       gamepause;
  logic [7:0] scan_code;
  logic       frame_valid;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .gamepause(gamepause), .scan_code(scan_code),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int nv, ne, lat;
  bit settled = 0;

  // Byte-level model of the keyboard state.
  bit m_r, m_sp, m_ar, m_p, m_brk, m_ext, m_pause;
  logic [7:0] m_scan;

  function automatic logic [4:0] m_up();
    if (m_r) return 5'h0A;
    if (m_sp || m_ar) return 5'h09;
    return 5'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_scan = b;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      if (!m_ext && b == 8'h29) m_sp = !m_brk;
      if (!m_ext && b == 8'h2D) m_r = !m_brk;
      if (!m_ext && b == 8'h4D) begin
        if (!m_brk && !m_p) m_pause = !m_pause;
        m_p = !m_brk;
      end
      if (m_ext && b == 8'h75) m_ar = !m_brk;
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic model_err();
    m_brk = 0;
    m_ext = 0;
  endtask

  always @(negedge clk) begin
    if (frame_valid) nv++;
    if (frame_err) ne++;
    if (rst_n) chk("valid_err_excl", {31'd0, frame_valid & frame_err}, 32'd0);
    if (rst_n && settled) begin
      chk("up", {27'd0, up}, {27'd0, m_up()});
      chk("gamepause", {31'd0, gamepause}, {31'd0, m_pause});
      chk("scan_code", {24'd0, scan_code}, {24'd0, m_scan});
      chk("idle_valid", {31'd0, frame_valid}, 32'd0);
      chk("idle_err", {31'd0, frame_err}, 32'd0);
    end
  end

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_valid && lat == 0) lat = i;
    end
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit good;
    settled = 0;
    nv = 0; ne = 0; lat = 0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? ^b : ~^b);
    send_bit(!bad_stop);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
    good = !bad_par && !bad_stop;
    chk("valid_cnt", nv, {31'd0, good});
    chk("err_cnt", ne, {31'd0, !good});
    if (good) begin
      chk("accept_latency", lat, 32'd3);
      model_byte(b);
    end else begin
      model_err();
    end
    settled = 1;
  endtask

  task automatic send_timeout();
    settled = 0;
    nv = 0; ne = 0; lat = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 50) @(negedge clk);
    chk("timeout_err_cnt", ne, 32'd1);
    chk("timeout_valid_cnt", nv, 32'd0);
    model_err();
    settled = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    m_scan = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_up", {27'd0, up}, 32'h0);
    chk("rst_pause", {31'd0, gamepause}, 32'h0);
    chk("rst_scan", {24'd0, scan_code}, 32'h0);
    chk("rst_valid", {31'd0, frame_valid}, 32'h0);
    chk("rst_err", {31'd0, frame_err}, 32'h0);
    rst_n = 1'b1;
    settled = 1;
    repeat (5) @(negedge clk);

    // Space make/break
    send_frame(8'h29, 0, 0);
    chk("lit_space_up", {27'd0, up}, 32'h09);
    chk("lit_space_scan", {24'd0, scan_code}, 32'h29);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);
    chk("lit_space_brk_up", {27'd0, up}, 32'h00);

    // Priority: restart over flap
    send_frame(8'h29, 0, 0);
    send_frame(8'h2D, 0, 0);
    chk("lit_prio_up", {27'd0, up}, 32'h0A);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h2D, 0, 0);
    chk("lit_prio_rel_up", {27'd0, up}, 32'h09);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);

    // Extended arrow, and non-extended 75 is unmapped
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("lit_arrow_up", {27'd0, up}, 32'h09);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("lit_plain75_up", {27'd0, up}, 32'h00);

    // Pause toggling with typematic repeats
    for (int i = 0; i < 3; i++) send_frame(8'h4D, 0, 0);
    chk("lit_pause_on", {31'd0, gamepause}, 32'h1);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h4D, 0, 0);
    send_frame(8'h4D, 0, 0);
    chk("lit_pause_off", {31'd0, gamepause}, 32'h0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h4D, 0, 0);

    // Break with no make
    send_frame(8'hF0, 0, 0);
    send_frame(8'h2D, 0, 0);

    // Frame errors; error after F0 clears the pending break
    send_frame(8'h29, 1, 0);
    chk("lit_par_err_scan", {24'd0, scan_code}, 32'h2D);
    send_frame(8'h2D, 0, 1);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h77, 1, 0);
    send_frame(8'h29, 0, 0);
    chk("lit_err_clears_brk", {27'd0, up}, 32'h09);

    // F0 survives a long idle gap
    send_frame(8'hF0, 0, 0);
    repeat (2000) @(negedge clk);
    send_frame(8'h29, 0, 0);
    chk("lit_gap_brk_up", {27'd0, up}, 32'h00);

    // Timeout mid-frame, then a clean restart key
    send_timeout();
    send_frame(8'h2D, 0, 0);
    chk("lit_after_timeout_up", {27'd0, up}, 32'h0A);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames and converts Set-2 scancodes into the level-held game command bus `up[4:0]` and the `gamepause` level consumed by the drawing/physics stage. It is the input stage directly upstream of the game-drawing block: `up` stays valid for as long as the key is physically held, so the slow game clocks (`clk_23`, `gameclk`) in that block can sample it.

## Interface
- `TIMEOUT_CYCLES`, default 200_000: number of `clk` cycles (2 ms at 100 MHz) without a PS/2 falling edge mid-frame before the frame is abandoned.
- `clk`  in  1  100 MHz system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous to `clk`.
- `up`  out  5  command level: 5'h0A = restart (R held), 5'h09 = flap (Space or Up-arrow held), 5'h00 = none.
- `gamepause`  out  1  pause level; toggles on each fresh press of P.
- `scan_code`  out  8  last correctly received byte.
- `frame_valid`  out  1  one-cycle pulse when a good byte is accepted.
- `frame_err`  out  1  one-cycle pulse on a parity, stop or timeout error.

## Operation
- **Synchronisation.** Each of `ps2_clk` and `ps2_data` passes through a 2-FF synchroniser, followed by one history FF on the clock. A falling edge is flagged when the synchronised clock is 0 and the history FF is 1. Data is sampled from the synchronised data line in that same cycle.
- **Receiver FSM.** All transitions are taken only on a falling-edge cycle, except the timeout.
  - IDLE: if data = 0 (start bit), go to DATA with bit count 0. If data = 1, stay in IDLE and flag nothing.
  - DATA: shift data in LSB-first; after the 8th bit go to PARITY.
  - PARITY: store the bit. The 8 data bits plus the parity bit must have an odd number of ones.
  - STOP: if stop = 1 and parity is good, the byte is accepted. Otherwise pulse `frame_err`, discard the byte, and clear the `brk` and `ext` flags. Either way, return to IDLE.
  - Timeout: a counter clears on every falling edge and runs in every state except IDLE. When it reaches `TIMEOUT_CYCLES`, return to IDLE, pulse `frame_err`, and clear `brk`/`ext`.
- **Byte interpretation** (accepted bytes only):
  - 8'hF0: set `brk`.
  - 8'hE0: set `ext`.
  - Any other byte ends the scancode. Clear `brk` and `ext` afterwards.
    - Key mapping: `ext`=0 with 8'h29 → space; `ext`=0 with 8'h2D → r; `ext`=0 with 8'h4D → p; `ext`=1 with 8'h75 → arrow.
    - Make (`brk`=0) sets the key's held flag. Break (`brk`=1) clears it. Unmapped codes change nothing.
    - `gamepause` toggles only on a make of P while `p_held` = 0. Typematic repeats of P do not toggle.
- **Output encode** (registered):
  - `r_held` → `up` = 5'h0A. Restart wins when held together with flap.
  - Otherwise `space_held` | `arrow_held` → `up` = 5'h09.
  - Otherwise `up` = 5'h00.

## Timing
- **Reset values:** `up` = 0, `gamepause` = 0, `scan_code` = 0, `frame_valid` = 0, `frame_err` = 0; FSM in IDLE; all held, `brk` and `ext` flags = 0; timeout counter = 0.
- **Input latency:** a `ps2_clk` falling pin edge is detected 3 `clk` cycles later.
- **Byte acceptance:** with the stop-bit edge detected in cycle T, the following all update together in cycle T+1:
  - `frame_valid` pulses;
  - `scan_code` updates;
  - held flags update;
  - `up` and `gamepause` update.
- **Error pulse:** `frame_err` is asserted in cycle T+1 for STOP/parity errors, or in the cycle after the timeout compare.
- `frame_valid` and `frame_err` are never asserted together. Each is high for exactly 1 cycle.
- **Mid-frame reset:** reset asserted mid-frame clears everything immediately. The rest of the interrupted frame then arrives while the FSM is in IDLE and is decoded from whatever bit it next sees as a start bit; any resulting error is tolerated.
- **Break with no make:** a break for a key that is not held leaves it cleared, and `up` does not change.
- **F0 without a following code:** `brk` persists across an indefinite idle gap. Only an error or a terminating code clears it.

## Test plan
- **Space make/break:** send 8'h29 → `up` = 5'h09 one cycle after stop, `frame_valid` pulse, `scan_code` = 8'h29. Then send 8'hF0, 8'h29 → `up` = 5'h00.
- **Priority:** send make 8'h29, then make 8'h2D → `up` = 5'h0A. Send break 8'hF0 8'h2D → `up` returns to 5'h09.
- **Extended key:** send 8'hE0, 8'h75 → `up` = 5'h09. Then 8'hE0, 8'hF0, 8'h75 → 5'h00. A plain (non-extended) 8'h75 leaves `up` = 5'h00.
- **Pause toggling:** send 8'h4D three times (typematic) → `gamepause` goes 0→1 once. Send break, then 8'h4D again → `gamepause` = 0.
- **Frame errors:**
  - 8'h29 with wrong parity → `frame_err` pulse, `up` stays 5'h00, `scan_code` unchanged.
  - Stop bit 0 → `frame_err`.
- **Timeout:** send start + 4 bits, then hold `ps2_clk` high for 200_000 cycles → `frame_err` pulse, FSM in IDLE. A following clean 8'h2D frame yields `up` = 5'h0A.
